// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit counter type and its update rule.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bp_pkg;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_SNT = 2'd0;
   localparam ctr_t CTR_WNT = 2'd1;
   localparam ctr_t CTR_WT  = 2'd2;
   localparam ctr_t CTR_ST  = 2'd3;

   // Saturating step of a 2-bit counter toward the observed outcome.
   function automatic ctr_t sat_update(input ctr_t c, input logic taken);
      ctr_t r;
      r = c;
      if (taken) begin
         if (c != CTR_ST) r = c + 2'd1;
      end else begin
         if (c != CTR_SNT) r = c - 2'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: array of 2-bit saturating counters, one read port, one update port.
// Latency: combinational read of registered counters; update lands on the next clock edge.
// Backpressure: none; an update is accepted every cycle wr_en_i is high.
module bp_pht
   import bp_pkg::*;
#(
   parameter int ENTRIES = 64,
   parameter int IDX_W   = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic             rd_taken_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             wr_is_jump_i,
   input  logic             wr_taken_i
);

   ctr_t ctr_q [ENTRIES];

   // Counters reset to weakly-not-taken; jumps pin their counter to strongly taken.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
      end else if (wr_en_i) begin
         ctr_q[wr_idx_i] <= wr_is_jump_i ? CTR_ST : sat_update(ctr_q[wr_idx_i], wr_taken_i);
      end
   end

   // MSB of the counter is the taken prediction.
   assign rd_taken_o = ctr_q[rd_idx_i][1];

endmodule

// File: rtl/branch_predictor_bht.sv
// Dynamic branch predictor: tagged direct-mapped BTB plus 2-bit PHT, bimodal or gshare indexed.
// Latency: lookup is combinational from registered state; updates take effect the next cycle.
// Backpressure: none; one lookup and one resolved update per cycle. Optional macro BP_STATS_EN adds stat counters.
module branch_predictor_bht
   import bp_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 64,
   parameter int TAG_W   = 8,
   parameter int GHR_W   = 0
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [XLEN-1:0]                       pc_if_i,
   output logic                                  pred_taken_o,
   output logic [XLEN-1:0]                       pred_target_o,
   output logic [((GHR_W > 0) ? GHR_W : 1)-1:0]  pred_ghr_o,
   input  logic                                  upd_valid_i,
   input  logic                                  upd_is_jump_i,
   input  logic [XLEN-1:0]                       upd_pc_i,
   input  logic                                  upd_taken_i,
   input  logic [XLEN-1:0]                       upd_target_i,
   input  logic                                  upd_pred_taken_i,
   input  logic [XLEN-1:0]                       upd_pred_target_i,
   input  logic [((GHR_W > 0) ? GHR_W : 1)-1:0]  upd_ghr_i,
   output logic                                  mispredict_o,
   output logic [XLEN-1:0]                       redirect_pc_o
`ifdef BP_STATS_EN
   ,
   output logic [31:0]                           stat_branches_o,
   output logic [31:0]                           stat_mispred_o
`endif
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int GW    = (GHR_W > 0) ? GHR_W : 1;

   // History folded into the index; bimodal builds ignore history entirely.
   function automatic logic [IDX_W-1:0] ghr_fold(input logic [GW-1:0] g);
      if (GHR_W > 0) return IDX_W'(g);
      else           return '0;
   endfunction

   logic [ENTRIES-1:0] btb_valid;
   logic [TAG_W-1:0]   btb_tag    [ENTRIES];
   logic [XLEN-1:0]    btb_target [ENTRIES];
   logic [GW-1:0]      ghr;

   logic [IDX_W-1:0]   if_idx, upd_idx, if_pht_idx, upd_pht_idx;
   logic [TAG_W-1:0]   if_tag, upd_tag;
   logic               hit, pht_taken, btb_write;

   assign if_idx      = pc_if_i[IDX_W+1:2];
   assign if_tag      = pc_if_i[IDX_W+TAG_W+1:IDX_W+2];
   assign upd_idx     = upd_pc_i[IDX_W+1:2];
   assign upd_tag     = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
   assign if_pht_idx  = if_idx ^ ghr_fold(ghr);
   // Update uses the history snapshot taken at fetch so it trains the same counter that predicted.
   assign upd_pht_idx = upd_idx ^ ghr_fold(upd_ghr_i);
   // Only taken outcomes allocate or overwrite a BTB entry.
   assign btb_write   = upd_valid_i && upd_taken_i;

   bp_pht #(
      .ENTRIES (ENTRIES),
      .IDX_W   (IDX_W)
   ) u_pht (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .rd_idx_i     (if_pht_idx),
      .rd_taken_o   (pht_taken),
      .wr_en_i      (upd_valid_i),
      .wr_idx_i     (upd_pht_idx),
      .wr_is_jump_i (upd_is_jump_i),
      .wr_taken_i   (upd_taken_i)
   );

   // BTB valid bits: cleared by reset, set on a taken update.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         btb_valid <= '0;
      end else if (btb_write) begin
         btb_valid[upd_idx] <= 1'b1;
      end
   end

   // BTB tag/target payload: no reset needed, guarded by the valid bit.
   always_ff @(posedge clk_i) begin
      if (btb_write) begin
         btb_tag[upd_idx]    <= upd_tag;
         btb_target[upd_idx] <= upd_target_i;
      end
   end

   // Non-speculative global history: shifts only on resolved conditional branches.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ghr <= '0;
      end else if (upd_valid_i && !upd_is_jump_i && (GHR_W > 0)) begin
         ghr <= GW'({ghr, upd_taken_i});
      end
   end

   // Fetch-side lookup; reset forces a not-taken, sequential prediction.
   always_comb begin
      hit           = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
      pred_taken_o  = !rst_i && hit && pht_taken;
      pred_target_o = pred_taken_o ? btb_target[if_idx] : pc_if_i + XLEN'(4);
      pred_ghr_o    = ghr;
   end

   // Resolution check: wrong direction, or taken with the wrong target.
   always_comb begin
      mispredict_o  = upd_valid_i &&
                      ((upd_taken_i != upd_pred_taken_i) ||
                       (upd_taken_i && (upd_target_i != upd_pred_target_i)));
      redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + XLEN'(4);
   end

`ifdef BP_STATS_EN
   // Saturating event counters for conditional branches and mispredicted cycles.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_branches_o <= '0;
         stat_mispred_o  <= '0;
      end else begin
         if (upd_valid_i && !upd_is_jump_i && (stat_branches_o != '1))
            stat_branches_o <= stat_branches_o + 32'd1;
         if (mispredict_o && (stat_mispred_o != '1))
            stat_mispred_o <= stat_mispred_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Testbench: a bimodal and a gshare (GHR_W=4) instance share one stimulus stream.
// Each is compared every cycle against an arithmetic reference model of the predictor rules.
module tb_branch_predictor_bht;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] pc_if, upd_pc, upd_target, upd_pred_target;
   logic        upd_valid, upd_is_jump, upd_taken, upd_pred_taken;
   logic [3:0]  upd_ghr4;
   logic        upd_ghr1;

   logic        b_pt, b_mp, g_pt, g_mp;
   logic [31:0] b_tgt, b_rd, g_tgt, g_rd;
   logic        b_ghr;
   logic [3:0]  g_ghr;
`ifdef BP_STATS_EN
   logic [31:0] b_sb, b_sm, g_sb, g_sm;
`endif

   branch_predictor_bht #(.GHR_W(0)) dut (
      .clk_i(clk), .rst_i(rst), .pc_if_i(pc_if),
      .pred_taken_o(b_pt), .pred_target_o(b_tgt), .pred_ghr_o(b_ghr),
      .upd_valid_i(upd_valid), .upd_is_jump_i(upd_is_jump), .upd_pc_i(upd_pc),
      .upd_taken_i(upd_taken), .upd_target_i(upd_target),
      .upd_pred_taken_i(upd_pred_taken), .upd_pred_target_i(upd_pred_target),
      .upd_ghr_i(upd_ghr1), .mispredict_o(b_mp), .redirect_pc_o(b_rd)
`ifdef BP_STATS_EN
      , .stat_branches_o(b_sb), .stat_mispred_o(b_sm)
`endif
   );

   branch_predictor_bht #(.GHR_W(4)) dut_g (
      .clk_i(clk), .rst_i(rst), .pc_if_i(pc_if),
      .pred_taken_o(g_pt), .pred_target_o(g_tgt), .pred_ghr_o(g_ghr),
      .upd_valid_i(upd_valid), .upd_is_jump_i(upd_is_jump), .upd_pc_i(upd_pc),
      .upd_taken_i(upd_taken), .upd_target_i(upd_target),
      .upd_pred_taken_i(upd_pred_taken), .upd_pred_target_i(upd_pred_target),
      .upd_ghr_i(upd_ghr4), .mispredict_o(g_mp), .redirect_pc_o(g_rd)
`ifdef BP_STATS_EN
      , .stat_branches_o(g_sb), .stat_mispred_o(g_sm)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model, index 0 = bimodal, 1 = gshare with 4 history bits.
   int          gw [2] = '{0, 4};
   bit          mvalid [2][64];
   int          mtag   [2][64];
   logic [31:0] mtgt   [2][64];
   int          mctr   [2][64];
   int          mghr   [2];
   int          mstb   [2];
   int          mstm   [2];
   bit          exp_mp;

   function automatic int bidx(input logic [31:0] pc);
      return int'((pc / 4) % 64);
   endfunction

   function automatic int btag(input logic [31:0] pc);
      return int'((pc / 256) % 256);
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 64; i++) begin
            mvalid[m][i] = 0;
            mctr[m][i]   = 1;
         end
         mghr[m] = 0;
         mstb[m] = 0;
         mstm[m] = 0;
      end
   endtask

   task automatic drive(input logic r, input logic [31:0] pc, input logic v, input logic j,
                        input logic [31:0] upc, input logic t, input logic [31:0] tgt,
                        input logic pt, input logic [31:0] ptgt, input logic [3:0] g);
      rst = r; pc_if = pc; upd_valid = v; upd_is_jump = j; upd_pc = upc;
      upd_taken = t; upd_target = tgt; upd_pred_taken = pt; upd_pred_target = ptgt;
      upd_ghr4 = g; upd_ghr1 = g[0];
   endtask

   // Compare all outputs against the model, then clock and advance the model.
   task automatic cycle();
      int          i, p, hist;
      bit          ept;
      logic [31:0] etgt, erd;
      #1;
      exp_mp = upd_valid && ((upd_taken != upd_pred_taken) ||
                             (upd_taken && (upd_target != upd_pred_target)));
      erd = upd_taken ? upd_target : upd_pc + 32'd4;
      for (int m = 0; m < 2; m++) begin
         i    = bidx(pc_if);
         p    = i ^ mghr[m];
         ept  = !rst && mvalid[m][i] && (mtag[m][i] == btag(pc_if)) && (mctr[m][p] >= 2);
         etgt = ept ? mtgt[m][i] : pc_if + 32'd4;
         check(m == 0 ? "b.pred_taken" : "g.pred_taken", 32'(m == 0 ? b_pt : g_pt), 32'(ept));
         check(m == 0 ? "b.pred_target" : "g.pred_target", m == 0 ? b_tgt : g_tgt, etgt);
         check(m == 0 ? "b.pred_ghr" : "g.pred_ghr", m == 0 ? 32'(b_ghr) : 32'(g_ghr), 32'(mghr[m]));
         check(m == 0 ? "b.mispredict" : "g.mispredict", 32'(m == 0 ? b_mp : g_mp), 32'(exp_mp));
         if (exp_mp)
            check(m == 0 ? "b.redirect" : "g.redirect", m == 0 ? b_rd : g_rd, erd);
`ifdef BP_STATS_EN
         check(m == 0 ? "b.stat_br" : "g.stat_br", m == 0 ? b_sb : g_sb, 32'(mstb[m]));
         check(m == 0 ? "b.stat_mp" : "g.stat_mp", m == 0 ? b_sm : g_sm, 32'(mstm[m]));
`endif
      end
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else if (upd_valid) begin
         for (int m = 0; m < 2; m++) begin
            hist = (gw[m] > 0) ? int'(upd_ghr4) : 0;
            i = bidx(upd_pc);
            p = i ^ hist;
            if (upd_taken) begin
               mvalid[m][i] = 1;
               mtag[m][i]   = btag(upd_pc);
               mtgt[m][i]   = upd_target;
            end
            if (upd_is_jump)    mctr[m][p] = 3;
            else if (upd_taken) mctr[m][p] = (mctr[m][p] < 3) ? mctr[m][p] + 1 : 3;
            else                mctr[m][p] = (mctr[m][p] > 0) ? mctr[m][p] - 1 : 0;
            if (!upd_is_jump) begin
               mstb[m]++;
               if (gw[m] > 0) mghr[m] = ((mghr[m] * 2) + int'(upd_taken)) % 16;
            end
            if (exp_mp) mstm[m]++;
         end
      end
      @(negedge clk);
   endtask

   logic [31:0] pool [8] = '{32'h100, 32'h200, 32'h104, 32'h10, 32'h14, 32'h300, 32'h1100, 32'h108};

   initial begin
      drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      model_reset();
      @(negedge clk);
      cycle();

      // Reset state: not taken, sequential target.
      drive(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("t1.pred_taken", 32'(b_pt), 32'd0);
      check("t1.pred_target", b_tgt, 32'h104);
      cycle();

      // First taken branch mispredicts; lookup in the same cycle still sees old state.
      drive(0, 32'h100, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104, 0);
      #1;
      check("t2.mispredict", 32'(b_mp), 32'd1);
      check("t2.redirect", b_rd, 32'h80);
      check("t2.same_cycle", 32'(b_pt), 32'd0);
      cycle();
      drive(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("t2.pred_taken", 32'(b_pt), 32'd1);
      check("t2.pred_target", b_tgt, 32'h80);
      cycle();

      // Saturation then decay.
      for (int k = 0; k < 3; k++) begin
         drive(0, 32'h100, 1, 0, 32'h100, 1, 32'h80, 1, 32'h80, 0);
         cycle();
      end
      drive(0, 32'h100, 1, 0, 32'h100, 0, 32'h80, 1, 32'h80, 0);
      cycle();
      drive(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("t3.ctr2_taken", 32'(b_pt), 32'd1);
      check("t3.ctr2_target", b_tgt, 32'h80);
      cycle();
      drive(0, 32'h100, 1, 0, 32'h100, 0, 32'h80, 1, 32'h80, 0);
      cycle();
      drive(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("t3.ctr1_taken", 32'(b_pt), 32'd0);
      check("t3.ctr1_target", b_tgt, 32'h104);
      cycle();

      // Aliasing: same index, different tag; JAL overwrites the entry.
      drive(0, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("t4.alias_miss", b_tgt, 32'h204);
      cycle();
      drive(0, 32'h200, 1, 1, 32'h200, 1, 32'h40, 0, 32'h204, 0);
      cycle();
      drive(0, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("t4.jal_hit", b_tgt, 32'h40);
      cycle();
      drive(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("t4.old_miss", b_tgt, 32'h104);
      cycle();

      // Correct prediction vs. wrong target.
      drive(0, 32'h0, 1, 0, 32'h300, 1, 32'h80, 1, 32'h80, 0);
      #1;
      check("t5.correct", 32'(b_mp), 32'd0);
      cycle();
      drive(0, 32'h0, 1, 0, 32'h300, 1, 32'h80, 1, 32'h90, 0);
      #1;
      check("t5.bad_target", 32'(b_mp), 32'd1);
      check("t5.redirect", b_rd, 32'h80);
      cycle();

      // gshare: two taken branches from 0x10 give history 0011, lookup uses PHT index 7.
      drive(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      drive(0, 32'h10, 1, 0, 32'h10, 1, 32'h50, 0, 32'h14, 4'd0);
      cycle();
      drive(0, 32'h10, 1, 0, 32'h10, 1, 32'h50, 0, 32'h14, 4'd1);
      cycle();
      drive(0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("t6.ghr", 32'(g_ghr), 32'h3);
      check("t6.idx7_taken", 32'(g_pt), 32'd0);
      check("t6.idx7_target", g_tgt, 32'h14);
      cycle();
      drive(1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("t6.rst_pred", 32'(b_pt), 32'd0);
      cycle();
      drive(0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("t6.ghr_clr", 32'(g_ghr), 32'd0);
      check("t6.post_miss", b_tgt, 32'h14);
`ifdef BP_STATS_EN
      check("t6.stat_br", g_sb, 32'd0);
      check("t6.stat_mp", g_sm, 32'd0);
`endif
      cycle();

      // Randomized traffic with occasional mid-run resets.
      for (int n = 0; n < 800; n++) begin
         logic        r, v, j, t, pt;
         logic [31:0] tgt, ptgt;
         r    = ($urandom_range(0, 59) == 0);
         v    = !r && ($urandom_range(0, 3) != 0);
         j    = ($urandom_range(0, 5) == 0);
         t    = j ? 1'b1 : 1'($urandom_range(0, 1));
         tgt  = 32'($urandom_range(0, 255)) * 4;
         pt   = 1'($urandom_range(0, 1));
         ptgt = ($urandom_range(0, 2) != 0) ? tgt : pool[$urandom_range(0, 7)];
         drive(r, pool[$urandom_range(0, 7)], v, j, pool[$urandom_range(0, 7)], t, tgt, pt, ptgt,
               4'($urandom_range(0, 15)));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
